// File: rtl/rob_pkg.sv
// Shared definitions for the multi-port reorder buffer.
// Holds the default configuration, the tag-width helper and the entry layout.
package rob_pkg;

   localparam int ROB_DEPTH  = 32;
   localparam int ROB_DATA_W = 32;
   localparam int ROB_REG_W  = 5;
   localparam int ROB_NUM_WB = 2;

   // Tag width needed to address every slot of a buffer of the given depth
   function automatic int rob_tag_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // One ROB slot at the default widths
   typedef struct packed {
      logic                  valid;
      logic                  ready;
      logic [ROB_REG_W-1:0]  dest;
      logic [ROB_DATA_W-1:0] value;
   } rob_entry_t;

endpackage

// File: rtl/rob_wb_arbiter.sv
// Folds NUM_WB common-data-bus writeback ports into one write-enable and one
// write value per ROB slot. When several ports target the same slot in the
// same cycle, the highest-numbered port wins.
module rob_wb_arbiter
   import rob_pkg::*;
#(
   parameter int DEPTH  = ROB_DEPTH,
   parameter int DATA_W = ROB_DATA_W,
   parameter int NUM_WB = ROB_NUM_WB,
   parameter int TAG_W  = rob_tag_width(ROB_DEPTH)
)(
   input  logic [NUM_WB-1:0]            wb_valid,
   input  logic [NUM_WB*TAG_W-1:0]      wb_tag,
   input  logic [NUM_WB*DATA_W-1:0]     wb_value,
   output logic [DEPTH-1:0]             wr_hit,
   output logic [DEPTH-1:0][DATA_W-1:0] wr_data
);

   // Per-slot port matching; later (higher) ports override earlier ones
   always_comb begin
      wr_hit  = '0;
      wr_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         for (int p = 0; p < NUM_WB; p++) begin
            if (wb_valid[p] && (wb_tag[p*TAG_W +: TAG_W] == TAG_W'(k))) begin
               wr_hit[k]  = 1'b1;
               wr_data[k] = wb_value[p*DATA_W +: DATA_W];
            end else begin
               wr_data[k] = wr_data[k];
            end
         end
      end
   end

endmodule

// File: rtl/rob_multiport.sv
// Parametrised reorder buffer: in-order allocation, out-of-order writeback
// from NUM_WB CDB ports, in-order retirement of up to two entries per cycle.
// Fullness is tracked by an occupancy counter so all DEPTH slots are usable.
// Optional branch-mispredict squash is enabled by defining ROB_FLUSH_EN.
module rob_multiport
   import rob_pkg::*;
#(
   parameter int DEPTH  = ROB_DEPTH,
   parameter int DATA_W = ROB_DATA_W,
   parameter int REG_W  = ROB_REG_W,
   parameter int NUM_WB = ROB_NUM_WB,
   parameter int TAG_W  = rob_tag_width(DEPTH)
)(
   input  logic                     clk,
   input  logic                     rst,
`ifdef ROB_FLUSH_EN
   input  logic                     flush,
   input  logic [TAG_W-1:0]         flush_tag,
`endif
   input  logic                     issue,
   input  logic [REG_W-1:0]         dest_reg,
   output logic [TAG_W-1:0]         tag,
   output logic                     write_rat,
   output logic                     full,
   output logic                     empty,
   output logic [TAG_W:0]           count,
   input  logic [NUM_WB-1:0]        wb_valid,
   input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
   input  logic [NUM_WB*DATA_W-1:0] wb_value,
   output logic                     commit1,
   output logic [REG_W-1:0]         commit_addr,
   output logic [DATA_W-1:0]        commit_val,
   output logic                     commit2,
   output logic [REG_W-1:0]         commit_addr2,
   output logic [DATA_W-1:0]        commit_val2
);

   localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(DEPTH);

   logic [DEPTH-1:0]             valid, ready;
   logic [DEPTH-1:0]             valid_nxt, ready_nxt;
   logic [REG_W-1:0]             dest_mem  [DEPTH];
   logic [DATA_W-1:0]            value_mem [DEPTH];
   logic [TAG_W-1:0]             head, tail, head_p1;
   logic [TAG_W-1:0]             head_nxt, tail_nxt;
   logic [TAG_W:0]               cnt, cnt_nxt;
   logic                         accept, lane1, lane2;
   logic [DEPTH-1:0]             wr_hit, wr_en;
   logic [DEPTH-1:0][DATA_W-1:0] wr_data;
   logic [DEPTH-1:0]             squash, retire_mask, alloc_mask;

   rob_wb_arbiter #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .NUM_WB (NUM_WB),
      .TAG_W  (TAG_W)
   ) u_wb_arbiter (
      .wb_valid (wb_valid),
      .wb_tag   (wb_tag),
      .wb_value (wb_value),
      .wr_hit   (wr_hit),
      .wr_data  (wr_data)
   );

   assign head_p1   = head + TAG_W'(1);
   assign full      = (cnt == DEPTH_CNT);
   assign empty     = (cnt == '0);
   assign count     = cnt;
   assign tag       = tail;
   assign write_rat = accept;

   // Next-state decision from pre-edge state: issue, writeback, retire, squash
   always_comb begin
`ifdef ROB_FLUSH_EN
      logic [TAG_W-1:0] flush_age;
      logic [TAG_W-1:0] age;
      flush_age = flush_tag - head;
      squash    = '0;
      for (int k = 0; k < DEPTH; k++) begin
         age       = TAG_W'(k) - head;
         squash[k] = flush & valid[k] & (age > flush_age);
      end
      accept = issue & ~full & ~flush;
      lane1  = valid[head] & ready[head];
      // a lane-2 candidate younger than the flush point is being squashed
      lane2  = lane1 & valid[head_p1] & ready[head_p1] &
               (~flush | (flush_age != '0));
`else
      squash = '0;
      accept = issue & ~full;
      lane1  = valid[head] & ready[head];
      lane2  = lane1 & valid[head_p1] & ready[head_p1];
`endif
      wr_en       = wr_hit & valid & ~squash;
      retire_mask = (lane1 ? (DEPTH'(1) << head)    : DEPTH'(0)) |
                    (lane2 ? (DEPTH'(1) << head_p1) : DEPTH'(0));
      alloc_mask  = accept ? (DEPTH'(1) << tail) : DEPTH'(0);
      valid_nxt   = (valid & ~squash & ~retire_mask) | alloc_mask;
      ready_nxt   = (ready | wr_en) & ~squash & ~retire_mask & ~alloc_mask;
      head_nxt    = head + TAG_W'({1'b0, lane1} + {1'b0, lane2});
`ifdef ROB_FLUSH_EN
      if (flush) begin
         tail_nxt = flush_tag + TAG_W'(1);
         cnt_nxt  = (TAG_W+1)'(flush_age) + (TAG_W+1)'(1)
                    - (TAG_W+1)'(lane1) - (TAG_W+1)'(lane2);
      end else begin
         tail_nxt = accept ? (tail + TAG_W'(1)) : tail;
         cnt_nxt  = cnt + (TAG_W+1)'(accept)
                    - (TAG_W+1)'(lane1) - (TAG_W+1)'(lane2);
      end
`else
      tail_nxt = accept ? (tail + TAG_W'(1)) : tail;
      cnt_nxt  = cnt + (TAG_W+1)'(accept)
                 - (TAG_W+1)'(lane1) - (TAG_W+1)'(lane2);
`endif
   end

   // Control state: slot flags, pointers and occupancy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= '0;
         ready <= '0;
         head  <= '0;
         tail  <= '0;
         cnt   <= '0;
      end else begin
         valid <= valid_nxt;
         ready <= ready_nxt;
         head  <= head_nxt;
         tail  <= tail_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Payload storage; only meaningful while the matching valid flag is set
   always_ff @(posedge clk) begin
      for (int k = 0; k < DEPTH; k++) begin
         if (wr_en[k]) begin
            value_mem[k] <= wr_data[k];
         end
      end
      if (accept) begin
         dest_mem[tail] <= dest_reg;
      end
   end

   // Registered retire ports: pulses every cycle, data holds when idle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         commit1      <= 1'b0;
         commit2      <= 1'b0;
         commit_addr  <= '0;
         commit_val   <= '0;
         commit_addr2 <= '0;
         commit_val2  <= '0;
      end else begin
         commit1 <= lane1;
         commit2 <= lane2;
         if (lane1) begin
            commit_addr <= dest_mem[head];
            commit_val  <= value_mem[head];
         end else begin
            commit_addr <= commit_addr;
            commit_val  <= commit_val;
         end
         if (lane2) begin
            commit_addr2 <= dest_mem[head_p1];
            commit_val2  <= value_mem[head_p1];
         end else begin
            commit_addr2 <= commit_addr2;
            commit_val2  <= commit_val2;
         end
      end
   end

endmodule

// File: tb/tb_rob_multiport.sv
// Bench for rob_multiport: a program-order queue model of in-flight
// instructions predicts every output each cycle; directed sequences add
// hand-computed literal expectations, then randomized traffic runs.
module tb_rob_multiport;

   localparam int DEPTH  = 32;
   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam int NUM_WB = 2;
   localparam int TAG_W  = 5;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     issue;
   logic [REG_W-1:0]         dest_reg;
   logic [TAG_W-1:0]         tag;
   logic                     write_rat, full, empty;
   logic [TAG_W:0]           count;
   logic [NUM_WB-1:0]        wb_valid;
   logic [NUM_WB*TAG_W-1:0]  wb_tag;
   logic [NUM_WB*DATA_W-1:0] wb_value;
   logic                     commit1, commit2;
   logic [REG_W-1:0]         commit_addr, commit_addr2;
   logic [DATA_W-1:0]        commit_val, commit_val2;
`ifdef ROB_FLUSH_EN
   logic                     flush = 1'b0;
   logic [TAG_W-1:0]         flush_tag = '0;
`endif

   always #5 clk = ~clk;

   rob_multiport #(
      .DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W), .NUM_WB(NUM_WB)
   ) dut (
      .clk(clk), .rst(rst),
`ifdef ROB_FLUSH_EN
      .flush(flush), .flush_tag(flush_tag),
`endif
      .issue(issue), .dest_reg(dest_reg), .tag(tag), .write_rat(write_rat),
      .full(full), .empty(empty), .count(count),
      .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
      .commit1(commit1), .commit_addr(commit_addr), .commit_val(commit_val),
      .commit2(commit2), .commit_addr2(commit_addr2), .commit_val2(commit_val2)
   );

   // In-flight instruction, oldest at the front of the queue
   typedef struct {
      int               tg;
      logic [REG_W-1:0] dest;
      bit               rdy;
      logic [DATA_W-1:0] val;
   } inst_t;

   inst_t             q[$];
   int                next_tag;
   logic              e_c1, e_c2;
   logic [REG_W-1:0]  e_a1, e_a2;
   logic [DATA_W-1:0] e_v1, e_v2;
   int                n_checks = 0;
   int                n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Asynchronous reset, checked while held; model cleared alongside
   task automatic do_reset();
      rst = 1'b0;
      issue = 1'b0; dest_reg = '0; wb_valid = '0; wb_tag = '0; wb_value = '0;
      #2;
      q.delete();
      next_tag = 0;
      e_c1 = 1'b0; e_c2 = 1'b0; e_a1 = '0; e_a2 = '0; e_v1 = '0; e_v2 = '0;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_tag", tag, 0);
      chk("rst_commit1", commit1, 0);
      chk("rst_commit2", commit2, 0);
      chk("rst_commit_addr", commit_addr, 0);
      chk("rst_commit_val", commit_val, 0);
      chk("rst_commit_addr2", commit_addr2, 0);
      chk("rst_commit_val2", commit_val2, 0);
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   // One clock cycle: drive, compare against model, advance model, compare commits
   task automatic step(input logic iss, input logic [REG_W-1:0] d,
                       input logic [NUM_WB-1:0] wv,
                       input logic [NUM_WB*TAG_W-1:0] wt,
                       input logic [NUM_WB*DATA_W-1:0] wd);
      bit    acc, l1, l2;
      inst_t e;
      issue = iss; dest_reg = d; wb_valid = wv; wb_tag = wt; wb_value = wd;
      #1;
      acc = iss && (q.size() < DEPTH);
      chk("tag", tag, next_tag);
      chk("write_rat", write_rat, acc);
      chk("full", full, q.size() == DEPTH);
      chk("empty", empty, q.size() == 0);
      chk("count", count, q.size());
      l1 = (q.size() >= 1) ? q[0].rdy : 1'b0;
      l2 = (l1 && q.size() >= 2) ? q[1].rdy : 1'b0;
      e_c1 = l1;
      e_c2 = l2;
      if (l1) begin e_a1 = q[0].dest; e_v1 = q[0].val; end
      if (l2) begin e_a2 = q[1].dest; e_v2 = q[1].val; end
      for (int p = 0; p < NUM_WB; p++) begin
         if (wv[p]) begin
            for (int i = 0; i < q.size(); i++) begin
               if (q[i].tg == int'(wt[p*TAG_W +: TAG_W])) begin
                  e = q[i];
                  e.rdy = 1'b1;
                  e.val = wd[p*DATA_W +: DATA_W];
                  q[i] = e;
               end
            end
         end
      end
      if (l1) void'(q.pop_front());
      if (l2) void'(q.pop_front());
      if (acc) begin
         e.tg = next_tag; e.dest = d; e.rdy = 1'b0; e.val = '0;
         q.push_back(e);
         next_tag = (next_tag + 1) % DEPTH;
      end
      @(posedge clk); #1;
      chk("commit1", commit1, e_c1);
      chk("commit2", commit2, e_c2);
      chk("commit_addr", commit_addr, e_a1);
      chk("commit_val", commit_val, e_v1);
      chk("commit_addr2", commit_addr2, e_a2);
      chk("commit_val2", commit_val2, e_v2);
   endtask

   task automatic idle();
      step(1'b0, '0, '0, '0, '0);
   endtask

   task automatic run_random(input int cycles, input int iss_pct, input int wb_pct);
      logic [NUM_WB-1:0]        wv;
      logic [NUM_WB*TAG_W-1:0]  wt;
      logic [NUM_WB*DATA_W-1:0] wd;
      for (int c = 0; c < cycles; c++) begin
         for (int p = 0; p < NUM_WB; p++) begin
            wv[p] = ($urandom_range(0, 99) < wb_pct);
            if (q.size() > 0 && $urandom_range(0, 4) != 0)
               wt[p*TAG_W +: TAG_W] = TAG_W'(q[$urandom_range(0, q.size()-1)].tg);
            else
               wt[p*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, DEPTH-1));
            wd[p*DATA_W +: DATA_W] = $urandom;
         end
         step($urandom_range(0, 99) < iss_pct, REG_W'($urandom), wv, wt, wd);
      end
   endtask

   initial begin
      rst = 1'b0;
      issue = 1'b0; dest_reg = '0; wb_valid = '0; wb_tag = '0; wb_value = '0;
      @(posedge clk); #1;
      do_reset();

      // Fill all 32 slots; tags come out 0..31
      for (int i = 0; i < DEPTH; i++) begin
         chk("fill_tag", tag, i);
         step(1'b1, REG_W'((i + 1) % DEPTH), '0, '0, '0);
      end
      chk("full_count", count, 32);
      chk("full_flag", full, 1);
      // 33rd issue is refused and the tail stays put
      step(1'b1, 5'd9, '0, '0, '0);
      chk("over_tag", tag, 0);
      chk("over_count", count, 32);

      // Make tags 0 and 1 ready, then retire both while issuing
      step(1'b0, '0, 2'b11, {5'd1, 5'd0}, {32'h101, 32'h100});
      chk("seq_32", count, 32);
      step(1'b1, 5'd7, '0, '0, '0);
      chk("seq_30", count, 30);
      chk("retire_v1", commit_val, 32'h100);
      chk("retire_v2", commit_val2, 32'h101);
      chk("rejected_tag", tag, 0);
      step(1'b1, 5'd7, '0, '0, '0);
      chk("seq_31", count, 31);
      chk("accepted_tag", tag, 1);

      // Drain to head=31, then retire 31 and 0 together across the wrap
      for (int t = 2; t <= 30; t++)
         step(1'b0, '0, 2'b01, {5'd0, TAG_W'(t)}, {32'h0, 32'hE00 + 32'(t)});
      step(1'b0, '0, 2'b11, {5'd0, 5'd31}, {32'hE00, 32'hE31});
      idle();
      chk("wrap_c1", commit1, 1);
      chk("wrap_c2", commit2, 1);
      chk("wrap_a1", commit_addr, 0);
      chk("wrap_a2", commit_addr2, 7);
      chk("wrap_v1", commit_val, 32'hE31);
      chk("wrap_v2", commit_val2, 32'hE00);
      idle();
      chk("wrap_empty", empty, 1);
      chk("wrap_head_tag", tag, 1);

      // Out-of-order writeback, dual retire of tags 0 and 1
      do_reset();
      step(1'b1, 5'd10, '0, '0, '0);
      step(1'b1, 5'd11, '0, '0, '0);
      step(1'b1, 5'd12, '0, '0, '0);
      step(1'b0, '0, 2'b01, {5'd0, 5'd1}, {32'h0, 32'hAA});
      step(1'b0, '0, 2'b01, {5'd0, 5'd0}, {32'h0, 32'h55});
      idle();
      chk("ooo_c1", commit1, 1);
      chk("ooo_v1", commit_val, 32'h55);
      chk("ooo_a1", commit_addr, 10);
      chk("ooo_c2", commit2, 1);
      chk("ooo_v2", commit_val2, 32'hAA);
      chk("ooo_count", count, 1);

      // Both ports hit tag 3: port 1 must win
      step(1'b1, 5'd13, '0, '0, '0);
      step(1'b0, '0, 2'b11, {5'd3, 5'd3}, {32'h22, 32'h11});
      step(1'b0, '0, 2'b01, {5'd0, 5'd2}, {32'h0, 32'h33});
      idle();
      chk("prio_v1", commit_val, 32'h33);
      chk("prio_v2", commit_val2, 32'h22);

      // Writeback to the slot being issued this cycle is dropped
      step(1'b1, 5'd20, 2'b01, {5'd0, 5'd4}, {32'h0, 32'h99});
      idle();
      chk("same_slot_c1", commit1, 0);
      step(1'b0, '0, 2'b11, {5'd9, 5'd4}, {32'hBAD, 32'h77});
      idle();
      chk("late_wb_c1", commit1, 1);
      chk("late_wb_v1", commit_val, 32'h77);
      chk("late_wb_a1", commit_addr, 20);

      // Randomized traffic: fill-heavy, balanced, drain-heavy
      run_random(1500, 90, 30);
      run_random(1500, 55, 60);
      run_random(500, 10, 90);
      run_random(300, 70, 50);
      // Reset in the middle of traffic, then keep going
      do_reset();
      run_random(300, 60, 60);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rob_multiport.md
Name: rob_multiport

Overview:
Parametrised reorder buffer, successor to the fixed 32-entry, 2-writeback ROB. Sits between issue/rename (RAT) and the register file.
- Allocates in-order tags at issue.
- Accepts out-of-order results from NUM_WB common-data-bus ports.
- Retires up to two ready instructions per cycle, in program order.
- Uses all DEPTH slots (full by occupancy count, not pointer adjacency) and exposes occupancy.

Parameters:
DEPTH, 32, number of entries; power of two, >= 4
DATA_W, 32, result value width
REG_W, 5, architectural register index width
NUM_WB, 2, number of CDB writeback ports, 1..4
TAG_W, $clog2(DEPTH), tag width (derived; do not override)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
issue  input  1  request to allocate one entry this cycle
dest_reg  input  REG_W  destination register of issuing instruction
tag  output  TAG_W  tag allocated on accepted issue; equals tail pointer (combinational)
write_rat  output  1  issue & ~full (combinational); RAT update strobe
full  output  1  count == DEPTH (combinational from registered count)
empty  output  1  count == 0
count  output  TAG_W+1  current occupancy
wb_valid  input  NUM_WB  per-port CDB write strobe
wb_tag  input  NUM_WB*TAG_W  per-port target tag, port i at [i*TAG_W +: TAG_W]
wb_value  input  NUM_WB*DATA_W  per-port result value
commit1  output  1  lane-1 retire pulse (registered)
commit_addr  output  REG_W  lane-1 destination register
commit_val  output  DATA_W  lane-1 value
commit2  output  1  lane-2 retire pulse (registered)
commit_addr2  output  REG_W  lane-2 destination register
commit_val2  output  DATA_W  lane-2 value

Behaviour:
- State: per-entry valid, ready, dest, value; head and tail pointers (TAG_W bits, modulo DEPTH wrap); count register.
- Reset (rst low, async): head=tail=count=0; all valid/ready=0; commit1=commit2=0; commit_addr/addr2/val/val2=0.
- Issue, accepted when issue && !full:
  - At the edge: entry[tail] gets valid=1, ready=0, dest=dest_reg; tail advances by 1.
  - full is the pre-edge value, so a retire in the same cycle does not unblock issue until the next cycle.
- Writeback: for each port i with wb_valid[i] and entry[wb_tag[i]].valid, set value and ready=1 at the edge.
  - Writes to non-valid entries are ignored.
  - Two ports hitting the same tag: the highest port index wins.
- Commit decision uses pre-edge state only.
  - lane1 = valid[head] & ready[head].
  - lane2 = lane1 & valid[head+1] & ready[head+1], wrap modulo DEPTH.
  - On the edge: retired entries get valid=ready=0, head advances by lane1+lane2, outputs are registered.
  - commit1/commit2 are one-cycle pulses, 0 when nothing retires.
  - commit_addr/val hold their last value when not retiring.
- Latency:
  - Writeback at edge N → earliest commit pulse is high during the cycle after edge N+1.
  - An instruction issued at edge N can be written back from cycle N+1 onward.
- count(next) = count + accepted_issue − lane1 − lane2; never exceeds DEPTH, never underflows.
- Wrap-around: pointers wrap DEPTH-1 → 0; lane2 at head=DEPTH-1 checks entry 0.
- Simultaneous issue into slot k and writeback to slot k: the writeback is ignored (pre-edge valid=0).
- Reset mid-operation clears everything immediately; no retire pulse is generated.

Optional Feature:
Macro ROB_FLUSH_EN.
- With it defined, two extra inputs are added: flush (1) and flush_tag (TAG_W) for branch-mispredict recovery.
  - On the edge with flush=1: all valid entries strictly younger than flush_tag are invalidated, tail = flush_tag+1 and count is recomputed.
  - Issue in the same cycle is ignored; write_rat is forced to 0.
  - Writebacks to squashed tags in that cycle are dropped.
  - Commit of entries at or older than flush_tag proceeds normally.
  - flush_tag must name a valid entry; otherwise behaviour is undefined.
- Without the macro: no ports are added and no squash logic exists.

Decomposition:
- Package rob_pkg: DEPTH, DATA_W, REG_W, NUM_WB defaults; TAG_W derivation function; entry struct typedef (valid, ready, dest, value).
- Sub-module rob_wb_arbiter: per-entry priority resolution of NUM_WB writeback ports into one write-enable and value per entry.

Test Plan:
- Reset then issue 32 instructions (DEPTH=32), dest 1..32 mod 32 → tags 0..31, full=1 and count=32 after the 32nd, a 33rd issue gives write_rat=0 and tail unchanged.
- Issue tags 0,1,2; write back tag1=0xAA then tag0=0x55 on a later cycle → commit1 pulse with 0x55, commit2 pulse with 0xAA in the same cycle; tag2 is not retired.
- Both ports write tag 3 in one cycle with 0x11 (port0) and 0x22 (port1) → tag 3 retires value 0x22.
- Fill to full, retire 2 and issue in the same cycle → issue rejected that cycle, accepted the next; count sequence 32,30,31.
- Head at 31, entries 31 and 0 ready → both retire in one cycle, head=1.
- ROB_FLUSH_EN: issue tags 0..5, flush_tag=2 → count=3, next tag=3, a writeback to tag 4 is ignored.
